count_sequence_checker: RTL and testbench

- Receive-side checker for the 3-bit sequence counter's `count` output and its `inorder` mode input.
- Each sample is compared against the successor predicted from the previous sample and its mode. The block reports lock, sequence errors and illegal codes, and keeps a saturating error count.
- Sits beside the counter in the test/monitor path; one clock domain.

---
 rtl/count_sequence_checker_pkg.sv | 57 +++++
 rtl/count_sequence_checker_if.sv | 24 ++
 rtl/count_sequence_checker_successor.sv | 20 ++
 rtl/count_sequence_checker.sv | 123 ++++++++++++
 tb/tb_count_sequence_checker.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/count_sequence_checker_pkg.sv
// Shared definitions for the 3-bit sequence counter and its receive-side checker:
// checker states, value constants and the successor function.
package count_seq_pkg;

  typedef enum logic [0:0] {
    ST_UNSYNC = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_t;

  localparam logic [2:0] VAL0        = 3'd0;
  localparam logic [2:0] VAL1        = 3'd1;
  localparam logic [2:0] VAL2        = 3'd2;
  localparam logic [2:0] VAL3        = 3'd3;
  localparam logic [2:0] VAL4        = 3'd4;
  localparam logic [2:0] VAL5        = 3'd5;
  localparam logic [2:0] VAL6        = 3'd6;
  localparam logic [2:0] VAL_ILLEGAL = 3'b111;

  typedef struct packed {
    logic [2:0] value;
    logic       hold;
  } succ_t;

  // In order mode parks on 6 once (hold set), then restarts at 1.
  function automatic succ_t count_succ(input logic [2:0] v, input logic m, input logic hold);
    succ_t r;
    r.value = VAL1;
    r.hold  = 1'b0;
    if (hold) begin
      r.value = VAL1;
    end else if (m) begin
      case (v)
        VAL0:    r.value = VAL1;
        VAL1:    r.value = VAL2;
        VAL2:    r.value = VAL3;
        VAL3:    r.value = VAL4;
        VAL4:    r.value = VAL5;
        VAL5:    r.value = VAL6;
        VAL6:    begin r.value = VAL6; r.hold = 1'b1; end
        default: r.value = VAL1;
      endcase
    end else begin
      case (v)
        VAL0:    r.value = VAL1;
        VAL1:    r.value = VAL4;
        VAL4:    r.value = VAL2;
        VAL2:    r.value = VAL5;
        VAL5:    r.value = VAL3;
        VAL3:    r.value = VAL6;
        VAL6:    r.value = VAL1;
        default: r.value = VAL1;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/count_sequence_checker_if.sv
// Sample stream into the checker and its status outputs.
interface count_sequence_checker_if #(
  parameter int ERR_W = 8
) ();
  logic             sample_en;
  logic [2:0]       count_in;
  logic             inorder;
  logic             locked;
  logic             seq_error;
  logic             illegal_err;
  logic [2:0]       expected;
  logic             ref_valid;
  logic [ERR_W-1:0] err_count;

  modport master (
    output sample_en, count_in, inorder,
    input  locked, seq_error, illegal_err, expected, ref_valid, err_count
  );

  modport slave (
    input  sample_en, count_in, inorder,
    output locked, seq_error, illegal_err, expected, ref_valid, err_count
  );
endinterface

// File: rtl/count_sequence_checker_successor.sv
// Combinational wrapper around count_succ, shared with counter models.
module count_successor
  import count_seq_pkg::*;
(
  input  logic [2:0] cur_value,
  input  logic       mode,
  input  logic       hold,
  output logic [2:0] next_value,
  output logic       next_hold
);
  succ_t nxt_s;

  // Evaluate the successor of the current value.
  always_comb begin
    nxt_s = count_succ(cur_value, mode, hold);
  end

  assign next_value = nxt_s.value;
  assign next_hold  = nxt_s.hold;
endmodule

// File: rtl/count_sequence_checker.sv
// Tracks the sequence counter output, predicts the next value and reports
// lock, sequence errors, illegal codes and a saturating error count.
module count_sequence_checker
  import count_seq_pkg::*;
#(
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  count_sequence_checker_if.slave  bus
);
  localparam logic [2:0]       LOCK_N_C = 3'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  chk_state_t       state_r;
  logic [2:0]       expected_r;
  logic             exp_hold_r;
  logic             ref_valid_r;
  logic [2:0]       match_cnt_r;
  logic             locked_r;
  logic             seq_error_r;
  logic             illegal_err_r;
  logic [ERR_W-1:0] err_count_r;

  logic             illegal_s;
  logic             match_s;
  logic             hold_new_s;
  logic [2:0]       succ_value_s;
  logic             succ_hold_s;
  logic [ERR_W-1:0] err_inc_s;
  logic [2:0]       match_inc_s;

  // The prediction is kept as expected value plus the hold flag the sample
  // will carry if it matches; a matching sample inherits that hold.
  assign illegal_s   = (bus.count_in == VAL_ILLEGAL);
  assign match_s     = ref_valid_r && (bus.count_in == expected_r);
  assign hold_new_s  = match_s && exp_hold_r;
  assign err_inc_s   = (err_count_r == ERR_MAX) ? err_count_r : (err_count_r + ERR_ONE);
  assign match_inc_s = match_cnt_r + 3'd1;

  count_successor u_succ (
    .cur_value  (bus.count_in),
    .mode       (bus.inorder),
    .hold       (hold_new_s),
    .next_value (succ_value_s),
    .next_hold  (succ_hold_s)
  );

  // Lock FSM, reference prediction, error pulses and error counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_UNSYNC;
      expected_r    <= 3'd0;
      exp_hold_r    <= 1'b0;
      ref_valid_r   <= 1'b0;
      match_cnt_r   <= 3'd0;
      locked_r      <= 1'b0;
      seq_error_r   <= 1'b0;
      illegal_err_r <= 1'b0;
      err_count_r   <= {ERR_W{1'b0}};
    end else begin
      seq_error_r   <= 1'b0;
      illegal_err_r <= 1'b0;
      if (bus.sample_en) begin
        if (illegal_s) begin
          illegal_err_r <= 1'b1;
          err_count_r   <= err_inc_s;
          ref_valid_r   <= 1'b0;
          exp_hold_r    <= 1'b0;
          match_cnt_r   <= 3'd0;
          state_r       <= ST_UNSYNC;
          locked_r      <= 1'b0;
        end else begin
          ref_valid_r <= 1'b1;
          expected_r  <= succ_value_s;
          exp_hold_r  <= succ_hold_s;
          case (state_r)
            ST_UNSYNC: begin
              if (match_s) begin
                match_cnt_r <= match_inc_s;
                if (match_inc_s == LOCK_N_C) begin
                  state_r  <= ST_LOCKED;
                  locked_r <= 1'b1;
                end else begin
                  locked_r <= 1'b0;
                end
              end else begin
                match_cnt_r <= 3'd0;
              end
            end
            ST_LOCKED: begin
              if (!match_s) begin
                seq_error_r <= 1'b1;
                err_count_r <= err_inc_s;
                state_r     <= ST_UNSYNC;
                locked_r    <= 1'b0;
                match_cnt_r <= 3'd0;
              end else begin
                locked_r <= 1'b1;
              end
            end
            default: begin
              state_r     <= ST_UNSYNC;
              locked_r    <= 1'b0;
              match_cnt_r <= 3'd0;
            end
          endcase
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.locked      = locked_r;
  assign bus.seq_error   = seq_error_r;
  assign bus.illegal_err = illegal_err_r;
  assign bus.expected    = expected_r;
  assign bus.ref_valid   = ref_valid_r;
  assign bus.err_count   = err_count_r;
endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: one task per scenario, inline checks.
module tb_count_sequence_checker;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  count_sequence_checker_if #(.ERR_W(8)) a ();
  count_sequence_checker_if #(.ERR_W(2)) b ();

  count_sequence_checker #(.LOCK_N(2), .ERR_W(8)) dut_a (.clock(clock), .reset(reset), .bus(a));
  count_sequence_checker #(.LOCK_N(2), .ERR_W(2)) dut_b (.clock(clock), .reset(reset), .bus(b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive_a(input logic [2:0] v, input logic m);
    @(negedge clock);
    a.sample_en = 1'b1; a.count_in = v; a.inorder = m;
    @(posedge clock); #1;
    a.sample_en = 1'b0;
  endtask

  task automatic idle_a();
    @(negedge clock);
    a.sample_en = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic drive_b(input logic [2:0] v, input logic m);
    @(negedge clock);
    b.sample_en = 1'b1; b.count_in = v; b.inorder = m;
    @(posedge clock); #1;
    b.sample_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; a.sample_en = 1'b0; b.sample_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if ({a.locked, a.seq_error, a.illegal_err, a.ref_valid} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {a.locked, a.seq_error, a.illegal_err, a.ref_valid}); end
    checks++; if (a.expected !== 3'd0) begin errors++; $display("FAIL reset_expected: got %0d want 0", a.expected); end
    checks++; if (a.err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", a.err_count); end
    checks++; if ({b.locked, b.ref_valid, b.err_count} !== 4'b0000) begin errors++; $display("FAIL reset_b: got %b want 0000", {b.locked, b.ref_valid, b.err_count}); end
  endtask

  task automatic test_inorder();
    logic [2:0] sv [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd1, 3'd2};
    logic [2:0] ev [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd1, 3'd2, 3'd3};
    logic       lk [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_a(sv[i], 1'b1);
      checks++; if (a.expected !== ev[i]) begin errors++; $display("FAIL inorder_expected[%0d]: got %0d want %0d", i, a.expected, ev[i]); end
      checks++; if (a.locked !== lk[i]) begin errors++; $display("FAIL inorder_locked[%0d]: got %0b want %0b", i, a.locked, lk[i]); end
      checks++; if (a.seq_error !== 1'b0) begin errors++; $display("FAIL inorder_seq_error[%0d]: got %0b want 0", i, a.seq_error); end
    end
    checks++; if (a.err_count !== 8'd0) begin errors++; $display("FAIL inorder_err_count: got %0d want 0", a.err_count); end
  endtask

  task automatic test_reorder();
    logic [2:0] sv [9] = '{3'd0, 3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd6, 3'd1, 3'd4};
    logic [2:0] ev [9] = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd6, 3'd1, 3'd4, 3'd2};
    logic       lk [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_a(sv[i], 1'b0);
      checks++; if (a.expected !== ev[i]) begin errors++; $display("FAIL reorder_expected[%0d]: got %0d want %0d", i, a.expected, ev[i]); end
      checks++; if (a.locked !== lk[i]) begin errors++; $display("FAIL reorder_locked[%0d]: got %0b want %0b", i, a.locked, lk[i]); end
    end
    checks++; if (a.err_count !== 8'd0) begin errors++; $display("FAIL reorder_err_count: got %0d want 0", a.err_count); end
  endtask

  task automatic test_seq_error();
    do_reset();
    drive_a(3'd0, 1'b1); drive_a(3'd1, 1'b1); drive_a(3'd2, 1'b1); drive_a(3'd3, 1'b1);
    checks++; if (a.locked !== 1'b1) begin errors++; $display("FAIL seqerr_prelock: got %0b want 1", a.locked); end
    drive_a(3'd3, 1'b1);
    checks++; if (a.seq_error !== 1'b1) begin errors++; $display("FAIL seqerr_pulse: got %0b want 1", a.seq_error); end
    checks++; if (a.locked !== 1'b0) begin errors++; $display("FAIL seqerr_unlock: got %0b want 0", a.locked); end
    checks++; if (a.err_count !== 8'd1) begin errors++; $display("FAIL seqerr_count: got %0d want 1", a.err_count); end
    checks++; if ({a.ref_valid, a.expected} !== 4'b1100) begin errors++; $display("FAIL seqerr_resync: got %b want 1100", {a.ref_valid, a.expected}); end
    drive_a(3'd4, 1'b1);
    checks++; if (a.seq_error !== 1'b0) begin errors++; $display("FAIL seqerr_one_cycle: got %0b want 0", a.seq_error); end
    checks++; if (a.locked !== 1'b0) begin errors++; $display("FAIL seqerr_relock_early: got %0b want 0", a.locked); end
    drive_a(3'd5, 1'b1);
    checks++; if (a.locked !== 1'b1) begin errors++; $display("FAIL seqerr_relock: got %0b want 1", a.locked); end
    checks++; if (a.err_count !== 8'd1) begin errors++; $display("FAIL seqerr_count_after: got %0d want 1", a.err_count); end
  endtask

  task automatic test_mode_toggle();
    logic [2:0] sv [6] = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd6, 3'd1};
    logic       md [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] ev [6] = '{3'd2, 3'd5, 3'd6, 3'd6, 3'd1, 3'd2};
    logic       lk [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_a(sv[i], md[i]);
      checks++; if (a.expected !== ev[i]) begin errors++; $display("FAIL toggle_expected[%0d]: got %0d want %0d", i, a.expected, ev[i]); end
      checks++; if ({a.locked, a.seq_error} !== {lk[i], 1'b0}) begin errors++; $display("FAIL toggle_status[%0d]: got %b want %b", i, {a.locked, a.seq_error}, {lk[i], 1'b0}); end
    end
    checks++; if (a.err_count !== 8'd0) begin errors++; $display("FAIL toggle_err_count: got %0d want 0", a.err_count); end
  endtask

  task automatic test_illegal_and_gaps();
    do_reset();
    drive_a(3'd0, 1'b1); drive_a(3'd1, 1'b1); drive_a(3'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      a.count_in = 3'd5; a.inorder = 1'b0;
      idle_a();
      checks++; if ({a.locked, a.seq_error, a.expected} !== 5'b10011) begin errors++; $display("FAIL gap_hold[%0d]: got %b want 10011", i, {a.locked, a.seq_error, a.expected}); end
    end
    drive_a(3'd3, 1'b1);
    checks++; if ({a.locked, a.expected} !== 4'b1100) begin errors++; $display("FAIL gap_resume: got %b want 1100", {a.locked, a.expected}); end
    drive_a(3'd7, 1'b1);
    checks++; if (a.illegal_err !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %0b want 1", a.illegal_err); end
    checks++; if ({a.ref_valid, a.locked, a.seq_error} !== 3'b000) begin errors++; $display("FAIL illegal_state: got %b want 000", {a.ref_valid, a.locked, a.seq_error}); end
    checks++; if (a.err_count !== 8'd1) begin errors++; $display("FAIL illegal_count: got %0d want 1", a.err_count); end
    idle_a();
    checks++; if ({a.illegal_err, a.err_count} !== 9'b0_0000_0001) begin errors++; $display("FAIL illegal_one_cycle: got %b want 000000001", {a.illegal_err, a.err_count}); end
    drive_a(3'd4, 1'b1);
    checks++; if ({a.ref_valid, a.locked, a.seq_error, a.expected} !== 6'b100101) begin errors++; $display("FAIL illegal_reload: got %b want 100101", {a.ref_valid, a.locked, a.seq_error, a.expected}); end
  endtask

  task automatic test_saturation();
    logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_b(3'd7, 1'b1);
      checks++; if ({b.illegal_err, b.err_count} !== {1'b1, ec[i]}) begin errors++; $display("FAIL sat_count[%0d]: got %b want %b", i, {b.illegal_err, b.err_count}, {1'b1, ec[i]}); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_a(3'd7, 1'b1); drive_a(3'd0, 1'b1); drive_a(3'd1, 1'b1); drive_a(3'd2, 1'b1);
    checks++; if ({a.locked, a.err_count} !== 9'b1_0000_0001) begin errors++; $display("FAIL areset_pre: got %b want 100000001", {a.locked, a.err_count}); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({a.locked, a.seq_error, a.illegal_err, a.ref_valid, a.expected} !== 7'd0) begin errors++; $display("FAIL areset_flags: got %b want 0000000", {a.locked, a.seq_error, a.illegal_err, a.ref_valid, a.expected}); end
    checks++; if (a.err_count !== 8'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", a.err_count); end
    @(negedge clock);
    reset = 1'b0;
    drive_a(3'd5, 1'b1);
    checks++; if ({a.ref_valid, a.locked, a.expected} !== 5'b10110) begin errors++; $display("FAIL areset_reload: got %b want 10110", {a.ref_valid, a.locked, a.expected}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    a.sample_en = 1'b0; a.count_in = 3'd0; a.inorder = 1'b1;
    b.sample_en = 1'b0; b.count_in = 3'd0; b.inorder = 1'b1;
    test_reset();
    test_inorder();
    test_reorder();
    test_seq_error();
    test_mode_toggle();
    test_illegal_and_gaps();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
